// File: rtl/prio_encoder_queue.sv
// prio_encoder_queue: sticky request capture with a registered valid/ready index output and overflow flag.
// Optional round-robin search enabled by PRIO_ENC_ROUND_ROBIN_EN; default is fixed highest-index priority.
module prio_encoder_queue #(
    parameter int N_IN  = 8,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  req_i,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  pend_o,
    output logic             ovf_o,
    input  logic             ovf_clr
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;
    logic [N_IN-1:0] pending, acc_mask, cand;
    logic [IDX_W-1:0] sel, idx_n;
    logic acc, ovf_set;
    assign out_valid = state == HOLD;
    assign pend_o    = pending;
    assign acc       = out_valid & out_ready;
    assign acc_mask  = acc ? (N_IN'(1) << out_idx) : '0;
    assign cand      = pending & ~acc_mask;
    // a request landing on a bit that is still pending and not being accepted is lost
    assign ovf_set   = |(req_i & pending & ~acc_mask);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr, ptr_n, j;
    assign ptr_n = acc ? ((out_idx == '0) ? IDX_W'(N_IN - 1) : out_idx - 1'b1) : ptr;
    // walk from lowest to highest priority so the entry at ptr_n overwrites last
    always_comb begin
        sel = '0;
        j   = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr_n) + N_IN - k) % N_IN);
            if (cand[j]) sel = j;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= IDX_W'(N_IN - 1);
        else     ptr <= ptr_n;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_IN; i++)
            if (cand[IDX_W'(i)]) sel = IDX_W'(i);
    end
`endif
    always_comb begin
        state_n = (state == IDLE) ? ((|cand) ? HOLD : IDLE) : ((acc && !(|cand)) ? IDLE : HOLD);
        idx_n   = ((state == IDLE || acc) && (|cand)) ? sel : out_idx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out_idx <= '0;
            pending <= '0;
            ovf_o   <= 1'b0;
        end else begin
            state   <= state_n;
            out_idx <= idx_n;
            pending <= cand | req_i;
            ovf_o   <= ovf_set | (ovf_o & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_prio_encoder_queue.sv
// tb_prio_encoder_queue: table-driven directed vectors plus hand-written async-reset and round-robin sequences.
module tb_prio_encoder_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_i = '0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] out_idx;
    logic       out_valid;
    logic [7:0] pend_o;
    logic       ovf_o;
    int checks = 0;
    int errors = 0;

    prio_encoder_queue #(.N_IN(8)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .pend_o(pend_o), .ovf_o(ovf_o), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] req;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] req, input logic rdy, input logic clr,
                       input logic v, input logic [2:0] idx, input logic [7:0] pend, input logic ovf);
        vec_t e;
        e.r = r; e.req = req; e.rdy = rdy; e.clr = clr;
        e.v = v; e.idx = idx; e.pend = pend; e.ovf = ovf;
        tbl.push_back(e);
    endtask

    // index is only meaningful while valid or right after reset
    task automatic check(input string name, input logic v, input logic idx_chk, input logic [2:0] idx,
                         input logic [7:0] pend, input logic ovf);
        checks++;
        if (out_valid !== v || (idx_chk && out_idx !== idx) || pend_o !== pend || ovf_o !== ovf) begin
            errors++;
            $display("FAIL %s: got valid=%b idx=%0d pend=%h ovf=%b, want valid=%b idx=%0d pend=%h ovf=%b",
                     name, out_valid, out_idx, pend_o, ovf_o, v, idx, pend, ovf);
        end
    endtask

    initial begin
        add(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h20, 0, 0, 0, 0, 8'h20, 0);
        for (int n = 0; n < 4; n++) add(0, 8'h00, 0, 0, 1, 5, 8'h20, 0);
        add(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h20, 0, 0, 0, 0, 8'h20, 0);
        for (int n = 0; n < 10; n++) add(0, 8'h00, 0, 0, 1, 5, 8'h20, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'hA5, 1, 0, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 1, 0, 1, 7, 8'hA5, 0);
        add(0, 8'h00, 1, 0, 1, 5, 8'h25, 0);
        add(0, 8'h00, 1, 0, 1, 2, 8'h05, 0);
        add(0, 8'h00, 1, 0, 1, 0, 8'h01, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'h08, 0, 0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 0, 1, 3, 8'h08, 0);
        add(0, 8'h08, 1, 0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 0, 1, 3, 8'h08, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'h02, 0, 0, 0, 0, 8'h02, 0);
        add(0, 8'h02, 0, 0, 1, 1, 8'h02, 1);
        add(0, 8'h00, 0, 1, 1, 1, 8'h02, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'h02, 0, 0, 0, 0, 8'h02, 0);
        add(0, 8'h02, 0, 1, 1, 1, 8'h02, 1);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        add(0, 8'hFF, 1, 0, 0, 0, 8'hFF, 0);
        add(0, 8'hFF, 1, 0, 1, 7, 8'hFF, 1);
        add(0, 8'h00, 1, 1, 1, 6, 8'h7F, 0);
        add(0, 8'h00, 1, 0, 1, 5, 8'h3F, 0);
        add(0, 8'h00, 1, 0, 1, 4, 8'h1F, 0);
        add(0, 8'h00, 1, 0, 1, 3, 8'h0F, 0);
        add(0, 8'h00, 1, 0, 1, 2, 8'h07, 0);
        add(0, 8'h00, 1, 0, 1, 1, 8'h03, 0);
        add(0, 8'h00, 1, 0, 1, 0, 8'h01, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);

        foreach (tbl[n]) begin
            @(negedge clk);
            rst = tbl[n].r; req_i = tbl[n].req; out_ready = tbl[n].rdy; ovf_clr = tbl[n].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", n), tbl[n].v, tbl[n].v | tbl[n].r, tbl[n].idx, tbl[n].pend, tbl[n].ovf);
        end

        @(negedge clk);
        rst = 0; req_i = 8'h81; out_ready = 0; ovf_clr = 0;
        @(negedge clk);
        req_i = 8'h00;
        @(posedge clk);
        #1;
        check("pre_async_rst", 1, 1, 7, 8'h81, 0);
        @(negedge clk);
        #2 rst = 1;
        #1 check("async_rst", 0, 1, 0, 8'h00, 0);
        @(negedge clk);
        rst = 0; out_ready = 1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 0, 0, 0, 8'h00, 0);
        end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
        @(negedge clk);
        req_i = 8'hFF;
        @(posedge clk);
        #1;
        check("rr_capture", 0, 0, 0, 8'hFF, 0);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr_step%0d", n), 1, 1, 3'(7 - (n % 8)), 8'hFF, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
